rr_pr_encoder: RTL and testbench
================================

// Module: rr_pr_encoder
// PURPOSE
//   Parametrised, registered N-input priority encoder. Successor to the 4:2 combinational encoders.
//   Encodes a request vector into a binary index plus a one-hot grant, in one of two modes:
//   - fixed priority: highest set bit wins
//   - round-robin: a rotating pointer sets the search start
//   Result is held in an output register with a valid/ready handshake, so downstream logic can stall it.
//   Sits between request sources (interrupt lines, channel requests) and a single shared consumer.
// PARAMETERS
//   N     8  number of request inputs, N >= 2
//   W     3  index width; must equal clog2(N)
//   MODE  0  0 = fixed priority (highest index wins), 1 = round-robin
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active-high
//   req        in   N    request vector; bit k = requester k active
//   out_ready  in   1    consumer accepts the current output this cycle
//   out_valid  out  1    out_idx/out_onehot/out_multi hold a valid encoding
//   out_idx    out  W    binary index of the winning requester
//   out_onehot out  N    one-hot of the winner (1 << out_idx); all-zero when !out_valid
//   out_multi  out  1    more than one req bit was set when the winner was captured
//   ack        out  N    one-cycle one-hot pulse to the winner on handshake (out_valid & out_ready)
// BEHAVIOUR
//   Clock and reset
//   - One clock (clk). Reset rst is asynchronous and active-high.
//   - On rst, all of these are 0: out_valid, out_idx, out_onehot, out_multi, ack, round-robin pointer ptr.
//   - Reset asserted mid-operation discards any held result immediately; no ack is issued.
//   Load rule
//   - load = !out_valid || out_ready (no bubble on back-to-back transfers).
//   - On a clock edge with load=1 and |req:
//     - out_valid <= 1
//     - out_idx <= winner
//     - out_onehot <= 1<<winner
//     - out_multi <= (popcount(req) > 1)
//   - On a clock edge with load=1 and req==0: out_valid <= 0. out_idx, out_onehot and out_multi go to 0.
//   - load=0 (out_valid & !out_ready): every output register holds. Changes on req are ignored until the next load.
//   Latency
//   - req sampled at edge t appears on the outputs after edge t (1 cycle).
//   ack
//   - Registered: ack <= (out_valid & out_ready) ? out_onehot : 0.
//   - So ack pulses in the cycle after the handshake, for exactly one cycle per transfer.
//   - Requesters are expected to drop req on ack.
//   - A req still high when the next load occurs is eligible again.
//   Winner selection
//   - MODE=0: winner = highest k with req[k]=1. ptr is unused and stays 0.
//   - MODE=1: search k = ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first set bit wins.
//   - MODE=1 pointer update: on every load with |req, ptr <= (winner == N-1) ? 0 : winner+1 (wrap).
//   - MODE=1: ptr does not change on a load with req==0 or while stalled.
//   Arithmetic and width
//   - All index arithmetic is W bits. Wrap is explicit at N-1, so N need not be a power of two.
//   - For non-power-of-two N, ptr never takes values >= N.
//   Boundaries
//   - Only bit N-1 set, MODE=1, ptr=N-1: winner = N-1, ptr wraps to 0.
//   - All bits set: out_multi = 1. MODE=0 gives winner N-1. MODE=1 gives winner = ptr.
//   - out_ready high while out_valid low: no ack, no effect beyond the load rule.
// TESTING  (N=8, W=3 unless noted)
//   1. Reset: assert rst async mid-cycle while out_valid=1.
//      -> out_valid, out_idx, out_onehot, ack, ptr go to 0 immediately; stay 0 while rst held.
//   2. MODE=0, out_ready=1: req=8'h01, then 8'h80, then 8'h0E, then 8'h06.
//      -> out_idx = 0, 7, 3, 2 one cycle later each; out_multi = 0, 0, 1, 1.
//   3. MODE=1, out_ready=1, req=8'hFF held.
//      -> out_idx sequence 0,1,2,...,7,0 on successive cycles; ack = 01,02,04,... one cycle behind.
//   4. MODE=1, req=8'h81, out_ready=1.
//      -> winners alternate 0,7,0,7.
//      -> A single req=8'h80 with ptr=7 gives idx=7, then ptr=0.
//   5. Stall: out_valid=1, idx=2, out_ready=0 for 3 cycles; req changes to 8'h10.
//      -> outputs hold idx=2, no ack.
//      -> On out_ready=1: ack=8'h04 the next cycle, and idx=4 loads on the same edge.
//   6. N=5, MODE=1, req=5'b10001.
//      -> winners 0,4,0,4; ptr never exceeds 4; req=0 -> out_valid drops to 0 after one cycle.

Source files
------------

// File: rtl/rr_pr_encoder.sv
// rr_pr_encoder: registered N-input priority encoder with a valid/ready output.
// MODE=0 picks the highest set request; MODE=1 searches round-robin from a
// rotating pointer that advances past each winner. The result is held in an
// output register that stalls while the consumer is not ready; ack pulses the
// winner one cycle after each accepted transfer.
module rr_pr_encoder #(
  parameter int N    = 8,
  parameter int W    = 3,   // must equal $clog2(N)
  parameter int MODE = 0    // 0 = fixed priority, 1 = round-robin
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi,
  output logic [N-1:0] ack
);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_multi;
  logic [N-1:0] r_ack;
  logic [W-1:0] r_ptr;

  logic         w_load;
  logic         w_any;
  logic         w_multi;
  logic [W-1:0] w_win;
  logic [W-1:0] w_ptr_nxt;
  logic [N-1:0] w_onehot;

  // Accept a new encoding whenever the output slot is empty or being drained.
  assign w_load   = !r_valid || out_ready;
  assign w_any    = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi  = |(req & (req - N'(1)));
  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;

  generate
    if (MODE == 1) begin : g_rr
      logic [W:0] w_k;
      logic       w_found;

      // Walk the requesters starting at the pointer, wrapping at N-1; first hit wins.
      always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
          w_k = {1'b0, r_ptr} + (W+1)'(i);
          if (w_k >= (W+1)'(N)) w_k = w_k - (W+1)'(N);
          if (!w_found && req[w_k[W-1:0]]) begin
            w_win   = w_k[W-1:0];
            w_found = 1'b1;
          end
        end
      end

      // Next search starts just past the winner; explicit wrap keeps ptr < N.
      always_comb begin
        w_ptr_nxt = (w_win == W'(N-1)) ? '0 : w_win + W'(1);
      end
    end else begin : g_fp
      // Highest set index wins: later iterations overwrite earlier ones.
      always_comb begin
        w_win = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i]) w_win = W'(i);
        end
      end

      // Fixed priority never moves the pointer; it stays at its reset value.
      assign w_ptr_nxt = r_ptr;
    end
  endgenerate

  // Round-robin pointer advances only on a load that produced a winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_ptr <= '0;
    else if (w_load && w_any) r_ptr <= w_ptr_nxt;
  end

  // Output register: load or clear on w_load, hold while stalled; ack trails the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_multi  <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_ack <= (r_valid && out_ready) ? r_onehot : '0;
      if (w_load) begin
        if (w_any) begin
          r_valid  <= 1'b1;
          r_idx    <= w_win;
          r_onehot <= w_onehot;
          r_multi  <= w_multi;
        end else begin
          r_valid  <= 1'b0;
          r_idx    <= '0;
          r_onehot <= '0;
          r_multi  <= 1'b0;
        end
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_multi  = r_multi;
  assign ack        = r_ack;

endmodule

// File: tb/tb_rr_pr_encoder.sv
// Bench for rr_pr_encoder: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) run directed sequences and random traffic against a
// behavioural model that tracks the held result, the pointer and ack.
module tb_rr_pr_encoder;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] req0, oh0, ack0;
  logic       rdy0, v0, mul0;
  logic [2:0] idx0;

  logic [7:0] req1, oh1, ack1;
  logic       rdy1, v1, mul1;
  logic [2:0] idx1;

  logic [4:0] req2, oh2, ack2;
  logic       rdy2, v2, mul2;
  logic [2:0] idx2;

  int checks   = 0;
  int failures = 0;

  // Model state per instance
  int mv[3], midx[3], mmul[3], mptr[3], mack[3];
  int mn[3]   = '{8, 8, 5};
  int mmode[3] = '{0, 1, 1};

  int t2_req[4]   = '{'h01, 'h80, 'h0E, 'h06};
  int t2_idx[4]   = '{0, 7, 3, 2};
  int t2_multi[4] = '{0, 0, 1, 1};

  always #5 clk = ~clk;

  rr_pr_encoder #(.N(8), .W(3), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .out_ready(rdy0), .out_valid(v0),
    .out_idx(idx0), .out_onehot(oh0), .out_multi(mul0), .ack(ack0));

  rr_pr_encoder #(.N(8), .W(3), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .out_ready(rdy1), .out_valid(v1),
    .out_idx(idx1), .out_onehot(oh1), .out_multi(mul1), .ack(ack1));

  rr_pr_encoder #(.N(5), .W(3), .MODE(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .out_ready(rdy2), .out_valid(v2),
    .out_idx(idx2), .out_onehot(oh2), .out_multi(mul2), .ack(ack2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner from the rules: highest set bit, or first set bit scanning from ptr with wrap.
  function automatic int ref_winner(input int r, input int n, input int mode, input int p);
    if (mode == 0) begin
      for (int k = n - 1; k >= 0; k--) if (r[k]) return k;
    end else begin
      for (int i = 0; i < n; i++) if (r[(p + i) % n]) return (p + i) % n;
    end
    return 0;
  endfunction

  task automatic model_edge(input int u, input int r, input bit rd);
    int nack, w;
    if (rst) begin
      mv[u] = 0; midx[u] = 0; mmul[u] = 0; mptr[u] = 0; mack[u] = 0;
      return;
    end
    nack = (mv[u] != 0 && rd) ? (1 << midx[u]) : 0;
    if (mv[u] == 0 || rd) begin
      if (r != 0) begin
        w = ref_winner(r, mn[u], mmode[u], mptr[u]);
        mv[u] = 1; midx[u] = w; mmul[u] = ($countones(r) > 1) ? 1 : 0;
        if (mmode[u] == 1) mptr[u] = (w + 1) % mn[u];
      end else begin
        mv[u] = 0; midx[u] = 0; mmul[u] = 0;
      end
    end
    mack[u] = nack;
  endtask

  task automatic chk_unit(input int u, input logic [31:0] v, input logic [31:0] idx,
                          input logic [31:0] oh, input logic [31:0] mul,
                          input logic [31:0] ak, input logic [31:0] p);
    chk($sformatf("u%0d_valid", u),  v,   32'(mv[u]));
    chk($sformatf("u%0d_idx", u),    idx, 32'(midx[u]));
    chk($sformatf("u%0d_onehot", u), oh,  (mv[u] != 0) ? 32'(1 << midx[u]) : 32'd0);
    chk($sformatf("u%0d_multi", u),  mul, 32'(mmul[u]));
    chk($sformatf("u%0d_ack", u),    ak,  32'(mack[u]));
    chk($sformatf("u%0d_ptr", u),    p,   32'(mptr[u]));
  endtask

  task automatic check_all();
    chk_unit(0, 32'(v0), 32'(idx0), 32'(oh0), 32'(mul0), 32'(ack0), 32'(dut0.r_ptr));
    chk_unit(1, 32'(v1), 32'(idx1), 32'(oh1), 32'(mul1), 32'(ack1), 32'(dut1.r_ptr));
    chk_unit(2, 32'(v2), 32'(idx2), 32'(oh2), 32'(mul2), 32'(ack2), 32'(dut2.r_ptr));
  endtask

  // One clock: model samples the same inputs the DUT saw, then compare 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge(0, int'(req0), rdy0);
    model_edge(1, int'(req1), rdy1);
    model_edge(2, int'(req2), rdy2);
    #1;
    check_all();
  endtask

  initial begin
    rst  = 1'b1;
    req0 = '0; req1 = '0; req2 = '0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    step();
    step();
    chk("rst_valid0", 32'(v0), 32'd0);
    rst = 1'b0;

    // Directed: fixed-priority patterns then a stall on u0; round-robin sweeps on u1/u2.
    for (int i = 0; i < 15; i++) begin
      if (i < 4)                 begin req0 = 8'(t2_req[i]); rdy0 = 1'b1; end
      else if (i < 7)            begin req0 = 8'h10;         rdy0 = 1'b0; end
      else if (i == 7)           begin req0 = 8'h10;         rdy0 = 1'b1; end
      else                       begin req0 = 8'h00;         rdy0 = 1'b1; end
      if (i < 9)                 req1 = 8'hFF;
      else if (i == 9)           req1 = 8'h40;
      else if (i == 10)          req1 = 8'h80;
      else                       req1 = 8'h81;
      rdy1 = 1'b1;
      req2 = (i < 9) ? 5'b10001 : 5'b00000;
      rdy2 = 1'b1;
      step();
      if (i < 4) begin
        chk("t2_idx",   32'(idx0), 32'(t2_idx[i]));
        chk("t2_multi", 32'(mul0), 32'(t2_multi[i]));
      end else if (i < 7) begin
        chk("t5_hold_idx", 32'(idx0), 32'd2);
        if (i > 4) chk("t5_no_ack", 32'(ack0), 32'd0);
      end else if (i == 7) begin
        chk("t5_ack", 32'(ack0), 32'h04);
        chk("t5_idx", 32'(idx0), 32'd4);
      end
      if (i < 9) begin
        chk("t3_idx", 32'(idx1), 32'(i % 8));
        chk("t3_ack", 32'(ack1), (i == 0) ? 32'd0 : 32'(1 << ((i - 1) % 8)));
        chk("t6_idx", 32'(idx2), (i % 2 == 0) ? 32'd0 : 32'd4);
      end
      if (i == 9)  chk("t6_drop", 32'(v2), 32'd0);
      if (i == 10) begin
        chk("t4_single_idx", 32'(idx1), 32'd7);
        chk("t4_ptr_wrap",   32'(dut1.r_ptr), 32'd0);
      end
      if (i > 10) chk("t4_alt", 32'(idx1), (i % 2 == 1) ? 32'd0 : 32'd7);
    end

    // Random traffic: mix of idle, single-bit and dense requests, random backpressure.
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel  = $urandom_range(0, 3);
      req0 = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      sel  = $urandom_range(0, 3);
      req1 = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      sel  = $urandom_range(0, 3);
      req2 = (sel == 0) ? 5'h00 : (sel == 1) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      rdy0 = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
      rdy2 = ($urandom_range(0, 3) != 0);
      step();
      chk("t6_ptr_range", 32'(dut2.r_ptr < 3'd5), 32'd1);
    end

    // Asynchronous reset in the middle of a cycle while results are held.
    req0 = 8'h0F; req1 = 8'hF0; req2 = 5'h1F;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    step();
    chk("t1_pre_valid", 32'(v1), 32'd1);
    #2;
    rst = 1'b1;
    mv   = '{0, 0, 0}; midx = '{0, 0, 0}; mmul = '{0, 0, 0};
    mptr = '{0, 0, 0}; mack = '{0, 0, 0};
    #1;
    check_all();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
